// File: rtl/matmul_8x8_host_ctrl.sv
// Host-side sequencer for the 8x8 matrix-multiply datapath: streams A/B words
// into the operand BRAMs, runs the multiply with a timeout, then streams C out.
//
// state      | meaning
// IDLE       | waiting for go
// LOAD_A     | accepting A words, writing bank A
// LOAD_B     | accepting B words, writing bank B
// LOAD_FLUSH | last registered B write lands
// COMPUTE    | multiplier running, timeout counting
// RD_ADDR    | C read address presented
// RD_WAIT    | BRAM read latency, capture at end
// RD_OUT     | result word offered on the output stream
module matmul_8x8_host_ctrl #(
    parameter int DWIDTH  = 16,
    parameter int AWIDTH  = 7,
    parameter int A_WORDS = 8,
    parameter int B_WORDS = 8,
    parameter int C_WORDS = 16,
    parameter int C_BASE  = 0,
    parameter int TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    output logic                  busy,
    output logic                  run_done,
    output logic                  err,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DWIDTH-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DWIDTH-1:0]   out_data,
    output logic                  enable_writing_to_mem,
    output logic                  enable_reading_from_mem,
    output logic                  we_a,
    output logic                  we_b,
    output logic                  we_c,
    output logic                  start_mat_mul,
    output logic [AWIDTH-1:0]     addr_pi,
    output logic [4*DWIDTH-1:0]   data_pi,
    input  logic                  done_mat_mul,
    input  logic [4*DWIDTH-1:0]   data_from_out_mat
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [AWIDTH-1:0] A_LAST  = AWIDTH'(A_WORDS - 1);
    localparam logic [AWIDTH-1:0] B_LAST  = AWIDTH'(B_WORDS - 1);
    localparam logic [AWIDTH-1:0] C_LAST  = AWIDTH'(C_WORDS - 1);
    localparam logic [AWIDTH-1:0] C_START = AWIDTH'(C_BASE);
    localparam logic [CW-1:0]     TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_LOAD_FLUSH,
        S_COMPUTE,
        S_RD_ADDR,
        S_RD_WAIT,
        S_RD_OUT
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [AWIDTH-1:0]     r_ld_idx;
    logic [AWIDTH-1:0]     r_rd_idx;
    logic [CW-1:0]         r_cnt;
    logic                  r_we_a;
    logic                  r_we_b;
    logic [AWIDTH-1:0]     r_addr_wr;
    logic [4*DWIDTH-1:0]   r_data_pi;
    logic [4*DWIDTH-1:0]   r_out_data;
    logic                  r_err;
    logic                  r_run_done;

    logic                  w_loading;
    logic                  w_accept;
    logic                  w_ld_last;
    logic                  w_timeout;
    logic                  w_last_out;
    logic                  w_reading;

    assign w_loading = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
    assign w_accept  = in_valid && w_loading;
    assign w_reading = (r_state == S_RD_ADDR) || (r_state == S_RD_WAIT);

    always_comb begin
        w_next     = r_state;
        w_ld_last  = 1'b0;
        w_timeout  = 1'b0;
        w_last_out = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (go) w_next = S_LOAD_A;
            end
            S_LOAD_A: begin
                if (w_accept && r_ld_idx == A_LAST) begin
                    w_ld_last = 1'b1;
                    w_next    = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                if (w_accept && r_ld_idx == B_LAST) begin
                    w_ld_last = 1'b1;
                    w_next    = S_LOAD_FLUSH;
                end
            end
            S_LOAD_FLUSH: w_next = S_COMPUTE;
            S_COMPUTE: begin
                // done wins over a timeout landing on the same cycle
                if (done_mat_mul) begin
                    w_next = S_RD_ADDR;
                end else if (r_cnt == TO_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_RD_ADDR: w_next = S_RD_WAIT;
            S_RD_WAIT: w_next = S_RD_OUT;
            S_RD_OUT: begin
                if (out_ready) begin
                    if (r_rd_idx == C_LAST) begin
                        w_last_out = 1'b1;
                        w_next     = S_IDLE;
                    end else begin
                        w_next = S_RD_ADDR;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ld_idx   <= '0;
            r_rd_idx   <= '0;
            r_cnt      <= '0;
            r_we_a     <= 1'b0;
            r_we_b     <= 1'b0;
            r_addr_wr  <= '0;
            r_data_pi  <= '0;
            r_out_data <= '0;
            r_err      <= 1'b0;
            r_run_done <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_we_a     <= w_accept && (r_state == S_LOAD_A);
            r_we_b     <= w_accept && (r_state == S_LOAD_B);
            r_run_done <= w_last_out;

            if (w_accept) begin
                r_addr_wr <= r_ld_idx;
                r_data_pi <= in_data;
            end

            if (r_state == S_IDLE)
                r_ld_idx <= '0;
            else if (w_accept)
                r_ld_idx <= w_ld_last ? '0 : r_ld_idx + 1'b1;

            if (r_state == S_COMPUTE)
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;

            if (r_state == S_IDLE || r_state == S_COMPUTE)
                r_rd_idx <= '0;
            else if (r_state == S_RD_OUT && out_ready)
                r_rd_idx <= r_rd_idx + 1'b1;

            // BRAM has one cycle of read latency; data is valid during RD_WAIT
            if (r_state == S_RD_WAIT)
                r_out_data <= data_from_out_mat;

            if (r_state == S_IDLE && go)
                r_err <= 1'b0;
            else if (w_timeout)
                r_err <= 1'b1;
        end
    end

    assign busy                    = (r_state != S_IDLE);
    assign in_ready                = w_loading;
    assign enable_writing_to_mem   = w_loading || (r_state == S_LOAD_FLUSH);
    assign enable_reading_from_mem = w_reading;
    assign start_mat_mul           = (r_state == S_COMPUTE);
    assign we_c                    = (r_state == S_COMPUTE);
    assign we_a                    = r_we_a;
    assign we_b                    = r_we_b;
    assign addr_pi                 = w_reading ? (C_START + r_rd_idx) : r_addr_wr;
    assign data_pi                 = r_data_pi;
    assign out_valid               = (r_state == S_RD_OUT);
    assign out_data                = r_out_data;
    assign err                     = r_err;
    assign run_done                = r_run_done;

endmodule

// File: tb/tb_matmul_8x8_host_ctrl.sv
// Randomized bench for matmul_8x8_host_ctrl against a transaction-level model
// of the load / compute / unload sequence plus simple BRAM and multiplier models.
module tb_matmul_8x8_host_ctrl;

    localparam int DW = 16, AW = 7, W = 4 * DW;
    localparam int NA = 8, NB = 8, NC = 16, CB = 0, TO = 1023;

    logic clk = 0, reset = 1, go = 0, in_valid = 0, out_ready = 0, done_mat_mul = 0;
    logic [W-1:0] in_data = '0, data_from_out_mat = '0;
    logic busy, run_done, err, in_ready, out_valid;
    logic [W-1:0] out_data, data_pi;
    logic enable_writing_to_mem, enable_reading_from_mem, we_a, we_b, we_c, start_mat_mul;
    logic [AW-1:0] addr_pi;

    matmul_8x8_host_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .A_WORDS(NA), .B_WORDS(NB),
        .C_WORDS(NC), .C_BASE(CB), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .go(go), .busy(busy), .run_done(run_done), .err(err),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .enable_writing_to_mem(enable_writing_to_mem),
        .enable_reading_from_mem(enable_reading_from_mem),
        .we_a(we_a), .we_b(we_b), .we_c(we_c), .start_mat_mul(start_mat_mul),
        .addr_pi(addr_pi), .data_pi(data_pi), .done_mat_mul(done_mat_mul),
        .data_from_out_mat(data_from_out_mat));

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    logic [W-1:0] c_mem [0:127];
    int done_after = 0, cmp_cnt = 0;

    // C BRAM: one cycle read latency
    always @(posedge clk) if (enable_reading_from_mem) data_from_out_mat <= c_mem[addr_pi];

    // multiplier: raises done during the done_after-th cycle of start (0 = never)
    always @(negedge clk) begin
        if (start_mat_mul) begin
            cmp_cnt = cmp_cnt + 1;
            done_mat_mul = (done_after != 0) && (cmp_cnt >= done_after);
        end else begin
            cmp_cnt = 0;
            done_mat_mul = 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {busy, in_ready, out_valid, run_done, err, enable_writing_to_mem,
            enable_reading_from_mem, we_a, we_b, we_c, start_mat_mul}, 0);
        chk({tag, "_addr"}, addr_pi, 0);
        chk({tag, "_dpi"}, data_pi, 0);
        chk({tag, "_dout"}, out_data, 0);
    endtask

    // vmode: 0 words 1..16 always valid, 1 valid every other cycle, 2 random valid
    // rmode: 0 ready always, 1 random ready, 2 five-cycle stall on word 2
    task automatic run(input string tag, input int vmode, input int rmode, input int dafter,
                       input bit go_in_compute, input bit go_with_valid, input int abort_after);
        logic [W-1:0] words[$];
        logic [W-1:0] got_out[$];
        bit got_bank[$];
        logic [AW-1:0] got_addr[$];
        logic [W-1:0] got_data[$];
        logic [W-1:0] held;
        bit stalled = 0, go_sent = 0, go_pend = 0, finished = 0;
        int widx = 0, n_done = 0, scount = 0, stall_n = 0, cyc;

        for (int i = 0; i < NA + NB; i++)
            words.push_back(vmode == 0 ? W'(i + 1) : {$urandom, $urandom});
        for (int i = 0; i < 128; i++) c_mem[i] = {$urandom, $urandom};
        done_after = dafter;

        @(negedge clk);
        go = 1;
        in_valid = go_with_valid;
        in_data = words[0];
        chk({tag, "_idle_ready"}, in_ready, 0);

        for (cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            go = 0;
            if (cyc == 0) chk({tag, "_err_clr"}, err, 0);
            if (we_a || we_b) begin
                got_bank.push_back(we_b);
                got_addr.push_back(addr_pi);
                got_data.push_back(data_pi);
            end
            if (we_a && we_b) chk({tag, "_we_both"}, 1, 0);
            if (run_done) n_done++;
            if (start_mat_mul) scount++;
            if (go_pend) begin
                chk({tag, "_go_ignored"}, start_mat_mul, 1);
                go_pend = 0;
            end
            if (go_in_compute && !go_sent && start_mat_mul && cmp_cnt >= 10) begin
                go = 1;
                go_sent = 1;
                go_pend = 1;
            end
            if (stalled) begin
                chk({tag, "_stall_valid"}, out_valid, 1);
                chk({tag, "_stall_data"}, out_data, held);
            end
            stalled = 0;
            case (rmode)
                0: out_ready = 1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    out_ready = 1;
                    if (out_valid && got_out.size() == 2 && stall_n < 5) begin
                        out_ready = 0;
                        stall_n++;
                    end
                end
            endcase
            if (out_valid) begin
                if (out_ready) got_out.push_back(out_data);
                else begin
                    stalled = 1;
                    held = out_data;
                end
            end
            if (widx < NA + NB) begin
                in_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
                in_data = in_valid ? words[widx] : {$urandom, $urandom};
                if (in_valid && in_ready) widx++;
            end else begin
                in_valid = 0;
            end
            if (abort_after > 0 && widx >= abort_after) return;
            if (!busy && (n_done > 0 || err)) begin
                finished = 1;
                break;
            end
        end
        in_valid = 0;
        chk({tag, "_finished"}, finished, 1);
        repeat (3) begin
            @(negedge clk);
            if (run_done) n_done++;
        end

        chk({tag, "_nwrites"}, got_data.size(), NA + NB);
        for (int i = 0; i < NA + NB && i < got_data.size(); i++) begin
            chk({tag, "_wbank"}, got_bank[i], i >= NA);
            chk({tag, "_waddr"}, got_addr[i], (i < NA) ? i : i - NA);
            chk({tag, "_wdata"}, got_data[i], words[i]);
        end
        if (dafter == 0) begin
            chk({tag, "_to_cycles"}, scount, TO);
            chk({tag, "_to_err"}, err, 1);
            chk({tag, "_to_start"}, start_mat_mul, 0);
            chk({tag, "_to_busy"}, busy, 0);
            chk({tag, "_to_done"}, n_done, 0);
            chk({tag, "_to_nout"}, got_out.size(), 0);
        end else begin
            chk({tag, "_start_cycles"}, scount, dafter);
            chk({tag, "_err"}, err, 0);
            chk({tag, "_ndone"}, n_done, 1);
            chk({tag, "_nout"}, got_out.size(), NC);
            for (int i = 0; i < NC && i < got_out.size(); i++)
                chk({tag, "_out"}, got_out[i], c_mem[(CB + i) % 128]);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 0;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        run("seq", 0, 0, 40, 0, 0, 0);
        run("toggle_stall", 1, 2, 40, 0, 0, 0);
        run("go_noise", 2, 1, $urandom_range(5, 60), 1, 1, 0);
        run("done_1", 2, 1, 1, 0, 0, 0);

        run("abort", 0, 0, 40, 0, 0, NA + 3);
        chk("abort_in_loadb", {enable_writing_to_mem, in_ready, busy}, 3'b111);
        #3 reset = 1;
        in_valid = 0;
        @(negedge clk);
        chk_all_zero("mid_reset");
        reset = 0;
        run("after_reset", 2, 1, 40, 0, 0, 0);

        run("timeout", 2, 0, 0, 0, 0, 0);
        run("after_to", 0, 1, 17, 0, 0, 0);
        for (int k = 0; k < 3; k++)
            run("rand", 2, 1, $urandom_range(1, 80), 1, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matmul_8x8_host_ctrl.md
MATMUL_8X8_HOST_CTRL -- requirements
Module: matmul_8x8_host_ctrl

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, element width in bits.
REQ-002 SHALL have parameter AWIDTH, default 7, BRAM address width.
REQ-003 SHALL have parameter A_WORDS, default 8, number of 4*DWIDTH words loaded into the A banks.
REQ-004 SHALL have parameter B_WORDS, default 8, number of words loaded into the B banks.
REQ-005 SHALL have parameter C_WORDS, default 16, number of result words unloaded; C_BASE, default 0, first C read address.
REQ-006 SHALL have parameter TIMEOUT, default 1023, maximum COMPUTE cycles before error.
REQ-007 SHALL have ports: clk in 1 clock; reset in 1 asynchronous active-high reset (one clock; reset asynchronous, active-high).
REQ-008 SHALL have ports: go in 1 run command; busy out 1 not IDLE; run_done out 1 one-cycle completion pulse; err out 1 sticky timeout flag.
REQ-009 SHALL have ports: in_valid in 1; in_ready out 1; in_data in 4*DWIDTH load word stream (A words first, then B).
REQ-010 SHALL have ports: out_valid out 1; out_ready in 1; out_data out 4*DWIDTH result word stream.
REQ-011 SHALL have datapath ports: enable_writing_to_mem, enable_reading_from_mem, we_a, we_b, we_c, start_mat_mul out 1 each; addr_pi out AWIDTH; data_pi out 4*DWIDTH; done_mat_mul in 1; data_from_out_mat in 4*DWIDTH.

Function
REQ-012 SHALL implement states IDLE, LOAD_A, LOAD_B, LOAD_FLUSH, COMPUTE, RD_ADDR, RD_WAIT, RD_OUT.
REQ-013 SHALL leave IDLE for LOAD_A on the edge go is sampled high; go in any other state ignored; err cleared on that edge.
REQ-014 SHALL drive in_ready=1 only in LOAD_A/LOAD_B; a word is accepted when in_valid && in_ready.
REQ-015 SHALL register each accepted word: next cycle data_pi=word, addr_pi=load index (0-based, restarts at 0 for B), we_a=1 (LOAD_A word) or we_b=1 (LOAD_B word); both write enables 0 otherwise.
REQ-016 SHALL move LOAD_A->LOAD_B on acceptance of word A_WORDS-1, LOAD_B->LOAD_FLUSH on word B_WORDS-1, LOAD_FLUSH->COMPUTE after one cycle (final write).
REQ-017 SHALL hold enable_writing_to_mem=1 in LOAD_A, LOAD_B, LOAD_FLUSH; 0 elsewhere.
REQ-018 SHALL hold start_mat_mul=1 and we_c=1 throughout COMPUTE, counting cycles from 0.
REQ-019 SHALL leave COMPUTE for RD_ADDR (read index 0) on the edge done_mat_mul is sampled 1; start_mat_mul and we_c drop that edge.
REQ-020 SHALL, if count reaches TIMEOUT with done_mat_mul low, set err=1, drop start_mat_mul/we_c, return to IDLE, no run_done.
REQ-021 SHALL in RD_ADDR and RD_WAIT drive enable_reading_from_mem=1, addr_pi=C_BASE+read index (modulo 2^AWIDTH); RD_ADDR->RD_WAIT unconditionally.
REQ-022 SHALL capture data_from_out_mat into out_data at end of RD_WAIT (one-cycle BRAM latency) and enter RD_OUT with out_valid=1.
REQ-023 SHALL hold out_valid and out_data stable in RD_OUT until out_ready=1; on handshake go to RD_ADDR with index+1, or, for index C_WORDS-1, to IDLE pulsing run_done=1 for one cycle.
REQ-024 SHALL drive busy=1 in every state except IDLE; load/read indices sized AWIDTH, timeout counter sized to hold TIMEOUT.

Reset
REQ-025 SHALL on reset, at any time including mid-run, force IDLE and clear all outputs, indices and counters to 0 (err included); no write enable glitches high while reset asserted.
REQ-026 SHALL resume normally on the first go after reset deassertion.

Verification
REQ-027 SHALL pass: reset asserted during LOAD_B word 3 -> all outputs 0 next cycle, busy=0, in_ready=0; subsequent go restarts at LOAD_A address 0.
REQ-028 SHALL pass: go, in_valid held 1 with words 1..16, done_mat_mul raised 40 cycles into COMPUTE, out_ready=1 -> we_a on addresses 0..7 with data 1..8, we_b 0..7 with data 9..16, start_mat_mul high 40 cycles, 16 out words matching C BRAM contents at addresses 0..15, one run_done pulse.
REQ-029 SHALL pass: in_valid toggled every other cycle and out_ready low 5 cycles on word 2 -> exactly 16 writes, no duplicates, out_data unchanged while stalled.
REQ-030 SHALL pass: done_mat_mul never asserted -> after 1023 COMPUTE cycles err=1, start_mat_mul=0, busy=0, no run_done; next go clears err.
REQ-031 SHALL pass: go pulsed during COMPUTE and go with in_valid in same IDLE cycle -> no state change from the first, no word accepted in the IDLE cycle.
